// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate decoder feeding a DEPTH-entry output FIFO; define IMM_GEN_ILLEGAL_FLAG_EN to add out_illegal
module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt
`ifdef IMM_GEN_ILLEGAL_FLAG_EN
    ,
    output logic            out_illegal
`endif
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    logic [6:0]      w_op;
    logic [2:0]      w_fmt;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] r_imm [DEPTH];
    logic [2:0]      r_fmt [DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW-1:0]   r_cnt;
    logic            r_rdy;
    assign w_op  = instruction[6:0];
    assign w_fmt = (w_op inside {7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011}) ? 3'd1 :
                   (w_op == 7'b0100011)                     ? 3'd2 :
                   (w_op == 7'b1100011)                     ? 3'd3 :
                   (w_op inside {7'b0110111, 7'b0010111})   ? 3'd4 :
                   (w_op == 7'b1101111)                     ? 3'd5 : 3'd0;
    assign w_imm32 = (w_fmt == 3'd1) ? {{20{instruction[31]}}, instruction[31:20]} :
                     (w_fmt == 3'd2) ? {{20{instruction[31]}}, instruction[31:25], instruction[11:7]} :
                     (w_fmt == 3'd3) ? {{19{instruction[31]}}, instruction[31], instruction[7],
                                        instruction[30:25], instruction[11:8], 1'b0} :
                     (w_fmt == 3'd4) ? {instruction[31:12], 12'b0} :
                     (w_fmt == 3'd5) ? {{11{instruction[31]}}, instruction[31], instruction[19:12],
                                        instruction[20], instruction[30:21], 1'b0} : 32'd0;
    assign w_imm = XLEN'($signed(w_imm32));
    // in_ready also waits one edge after reset release, via r_rdy
    assign in_ready  = r_rdy && (r_cnt < CW'(DEPTH));
    assign out_valid = (r_cnt != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign out_imm   = r_imm[r_head];
    assign out_fmt   = r_fmt[r_head];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
            r_rdy  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_imm[i] <= '0;
                r_fmt[i] <= '0;
            end
        end else begin
            r_rdy <= 1'b1;
            if (w_push) begin
                r_imm[r_tail] <= w_imm;
                r_fmt[r_tail] <= w_fmt;
                r_tail        <= r_tail + AW'(1);
            end
            if (w_pop)
                r_head <= r_head + AW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end
`ifdef IMM_GEN_ILLEGAL_FLAG_EN
    logic w_ill;
    logic r_ill [DEPTH];
    assign w_ill       = (w_fmt == 3'd0) && (w_op != 7'b0110011) && (w_op != 7'b0111011);
    assign out_illegal = r_ill[r_head];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_ill[i] <= 1'b0;
        end else if (w_push) begin
            r_ill[r_tail] <= w_ill;
        end
    end
`endif
endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 64; output immediate width, legal values 32 or 64.
REQ-002 SHALL have parameter DEPTH, default 2; output buffer entries, power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit; single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit; asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit; instruction offered.
REQ-006 SHALL have port in_ready, output, 1 bit; block accepts the instruction.
REQ-007 SHALL have port instruction, input, 32 bits; raw RISC-V instruction word.
REQ-008 SHALL have port out_valid, output, 1 bit; buffer head valid.
REQ-009 SHALL have port out_ready, input, 1 bit; consumer takes the head.
REQ-010 SHALL have port out_imm, output, XLEN bits; sign-extended immediate.
REQ-011 SHALL have port out_fmt, output, 3 bits; format code 0=none/R, 1=I, 2=S, 3=B, 4=U, 5=J.

Function
REQ-012 SHALL decode the format from opcode instruction[6:0]:
- I: 0000011, 0010011, 0011011, 1100111, 1110011.
- S: 0100011.
- B: 1100011.
- U: 0110111, 0010111.
- J: 1101111.
- All other opcodes: fmt 0, imm 0.
REQ-013 SHALL assemble the immediate bit fields per the RV32I/RV64I base encodings:
- B and J: bit 0 forced to 0.
- U: low 12 bits zero.
REQ-014 SHALL sign-extend every immediate from instruction[31] to XLEN bits, including U-type when XLEN=64.
REQ-015 SHALL accept a word when in_valid and in_ready are both 1 at a rising edge, and write the decoded {imm, fmt} into the buffer tail.
REQ-016 SHALL complete a transfer when out_valid and out_ready are both 1, and advance the head on that edge.
REQ-017 SHALL make an accepted word visible on out_* exactly one cycle after acceptance when the buffer was empty.
REQ-018 SHALL drive in_ready = (count < DEPTH), registered-count based, with no combinational path from out_ready.
REQ-019 SHALL handle a simultaneous push and pop with the buffer neither empty nor full by leaving count unchanged.
REQ-020 SHALL wrap head and tail pointers modulo DEPTH.
REQ-021 SHALL drive out_valid = (count != 0).
REQ-022 SHALL hold out_imm and out_fmt stable while out_valid=1 and out_ready=0.
REQ-023 SHALL preserve acceptance order on output (FIFO).
REQ-024 SHALL ignore instruction while in_valid=0; no state change.

Reset
REQ-025 SHALL, on rst_n low at any time including mid-transfer, immediately force:
- count, head and tail to 0;
- out_valid 0 and in_ready 0;
- out_imm 0 and out_fmt 0.
Buffered entries are discarded.
REQ-026 SHALL drive in_ready to 1 on the first clk edge after rst_n deasserts.

Configuration
REQ-027 SHALL support macro IMM_GEN_ILLEGAL_FLAG_EN.
- Defined: adds output port out_illegal, 1 bit, buffered alongside imm.
  - 1 for any opcode not listed in REQ-012 and not R-type 0110011/0111011.
  - Reset value 0.
- Undefined: port absent; unknown opcodes yield fmt 0, imm 0 only.

Verification
REQ-028 SHALL cover these directed scenarios (XLEN=64, DEPTH=2):
- Empty buffer, push 0xFFF00093 (addi -1) with out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFFFFFFFFFF, out_fmt=1.
- Push 0xFE112E23 (sw -4) -> out_imm=0xFFFFFFFFFFFFFFFC, fmt=2.
- Push 0x00000863 (beq +16) -> out_imm=0x10, fmt=3.
- Push 0x800000B7 (lui 0x80000) -> out_imm=0xFFFFFFFF80000000, fmt=4.
- Backpressure and ordering:
  - With out_ready=0, push 0xFFF00093 then 0x800000B7 -> in_ready=0, third word held.
  - Raise out_ready -> outputs appear in order; in_ready returns 1 after the first pop.
- Reset mid-operation:
  - Assert rst_n=0 with 2 entries buffered -> out_valid=0 immediately, all out_* 0.
  - After release -> in_ready=1 and no stale entry emerges.
- With IMM_GEN_ILLEGAL_FLAG_EN defined:
  - Push 0x0000007F -> out_illegal=1, fmt=0, imm=0.
  - Push 0x002081B3 (add) -> out_illegal=0.
